// File: rtl/seg_capture_if.sv
// Seven-segment capture bus: multiplexed display lines in, decoded frame out.
interface seg_capture_if;
  logic [6:0]  seg;          // segment lines g..a, active-low
  logic [3:0]  an;           // digit enables, active-low
  logic        err_clr;      // clears the sticky error flag
  logic [15:0] digits;       // last complete frame, digit0 in [3:0]
  logic [3:0]  blank;        // per-digit all-off flag of last frame
  logic        frame_valid;  // one-cycle pulse when digits/blank update
  logic        err;          // sticky unrecognised-pattern flag

  modport master (
    output seg, an, err_clr,
    input  digits, blank, frame_valid, err
  );

  modport slave (
    input  seg, an, err_clr,
    output digits, blank, frame_valid, err
  );
endinterface

// File: rtl/seg_capture.sv
// Sniffs a multiplexed active-low seven-segment display, waits for each
// digit to settle, decodes it and publishes a complete four-digit frame.
module seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_capture_if.slave  bus
);

  localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  // True when exactly one digit enable is driven low.
  function automatic logic one_low(input logic [3:0] an);
    logic ok;
    case (an)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Digit slot selected by a one-low enable pattern.
  function automatic logic [1:0] an_index(input logic [3:0] an);
    logic [1:0] idx;
    case (an)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Segment decode, returns {bad, blank, code[3:0]}.
  function automatic logic [5:0] decode(input logic [6:0] seg);
    logic [5:0] r;
    case (seg)
      7'b1000000: r = {1'b0, 1'b0, 4'h0};
      7'b1111001: r = {1'b0, 1'b0, 4'h1};
      7'b0100100: r = {1'b0, 1'b0, 4'h2};
      7'b0110000: r = {1'b0, 1'b0, 4'h3};
      7'b0011001: r = {1'b0, 1'b0, 4'h4};
      7'b0010010: r = {1'b0, 1'b0, 4'h5};
      7'b0000010: r = {1'b0, 1'b0, 4'h6};
      7'b1111000: r = {1'b0, 1'b0, 4'h7};
      7'b0000000: r = {1'b0, 1'b0, 4'h8};
      7'b0010000: r = {1'b0, 1'b0, 4'h9};
      7'b1111111: r = {1'b0, 1'b1, 4'hF};
      default:    r = {1'b1, 1'b0, 4'hE};
    endcase
    return r;
  endfunction

  logic [10:0] s_q, s_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  shadow_blank_q, shadow_blank_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  blank_q, blank_d;
  logic        frame_valid_q, frame_valid_d;
  logic        err_q, err_d;
  state_t      state_q, state_d;

  logic [10:0] sample_s;
  logic        capture_s;
  logic        cap_ok_s;
  logic        commit_s;
  logic [5:0]  dec_s;
  logic [1:0]  idx_s;
  logic [3:0]  mask_new_s;

  assign sample_s = {bus.an, bus.seg};

  // Sample register and settle counter; capture fires once when the count reaches the threshold.
  always_comb begin
    s_d       = sample_s;
    cnt_d     = cnt_q;
    capture_s = 1'b0;
    if (sample_s != s_q) begin
      cnt_d = 4'd0;
    end else if (cnt_q >= STABLE_C) begin
      cnt_d = STABLE_C;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
    if ((cnt_d == STABLE_C) && (cnt_q != STABLE_C)) begin
      capture_s = 1'b1;
    end else begin
      capture_s = 1'b0;
    end
  end

  // Decode the settled sample into the shadow frame and publish it when all four digits are in.
  always_comb begin
    dec_s          = decode(s_q[6:0]);
    idx_s          = an_index(s_q[10:7]);
    cap_ok_s       = capture_s && one_low(s_q[10:7]);
    mask_d         = mask_q;
    mask_new_s     = mask_q;
    shadow_d       = shadow_q;
    shadow_blank_d = shadow_blank_q;
    digits_d       = digits_q;
    blank_d        = blank_q;
    frame_valid_d  = 1'b0;
    commit_s       = 1'b0;
    if (cap_ok_s) begin
      shadow_d[{idx_s, 2'b00} +: 4] = dec_s[3:0];
      shadow_blank_d[idx_s]         = dec_s[4];
      mask_new_s                    = mask_q | (4'b0001 << idx_s);
      if (mask_new_s == 4'b1111) begin
        digits_d      = shadow_d;
        blank_d       = shadow_blank_d;
        frame_valid_d = 1'b1;
        mask_d        = 4'b0000;
        commit_s      = 1'b1;
      end else begin
        mask_d        = mask_new_s;
        commit_s      = 1'b0;
      end
    end else begin
      mask_d = mask_q;
    end
    // A bad capture outranks a simultaneous clear request.
    if (cap_ok_s && dec_s[5]) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Frame-progress state machine: next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (commit_s)      state_d = COMMIT;
        else if (cap_ok_s) state_d = COLLECT;
        else               state_d = IDLE;
      end
      COLLECT: begin
        if (commit_s)      state_d = COMMIT;
        else               state_d = COLLECT;
      end
      COMMIT: begin
        if (commit_s)      state_d = COMMIT;
        else if (cap_ok_s) state_d = COLLECT;
        else               state_d = IDLE;
      end
      default:             state_d = IDLE;
    endcase
  end

  // Frame-progress state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Sample, counter, shadow and output registers; reset drops any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q            <= 11'h7FF;
      cnt_q          <= 4'd0;
      mask_q         <= 4'b0000;
      shadow_q       <= 16'hFFFF;
      shadow_blank_q <= 4'hF;
      digits_q       <= 16'hFFFF;
      blank_q        <= 4'hF;
      frame_valid_q  <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      s_q            <= s_d;
      cnt_q          <= cnt_d;
      mask_q         <= mask_d;
      shadow_q       <= shadow_d;
      shadow_blank_q <= shadow_blank_d;
      digits_q       <= digits_d;
      blank_q        <= blank_d;
      frame_valid_q  <= frame_valid_d;
      err_q          <= err_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.blank       = blank_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture with STABLE_CYCLES = 4.
module tb_seg_capture;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SX = 7'b1010101;
  localparam logic [3:0] AN0 = 4'b1110;
  localparam logic [3:0] AN1 = 4'b1101;
  localparam logic [3:0] AN2 = 4'b1011;
  localparam logic [3:0] AN3 = 4'b0111;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   fv_count = 0;

  seg_capture_if bus();

  seg_capture #(.STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Count cycles with frame_valid high, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (bus.frame_valid === 1'b1) fv_count = fv_count + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [3:0] a, input logic [6:0] sg, input int n);
    bus.an  = a;
    bus.seg = sg;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.an      = 4'hF;
    bus.seg     = 7'h7F;
    bus.err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_digits", bus.digits, 16'hFFFF);
    chk("rst_blank", {12'd0, bus.blank}, 16'h000F);
    chk("rst_fv", {15'd0, bus.frame_valid}, 16'd0);
    chk("rst_err", {15'd0, bus.err}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Frame 1: 0123
    present(AN0, S3, 6);
    chk("f1_partial_fv", 16'(fv_count), 16'd0);
    chk("f1_partial_digits", bus.digits, 16'hFFFF);
    present(AN1, S2, 6);
    present(AN2, S1, 6);
    bus.an  = AN3;
    bus.seg = S0;
    repeat (4) @(negedge clk);
    chk("f1_fv_before", {15'd0, bus.frame_valid}, 16'd0);
    @(negedge clk);
    chk("f1_fv_edge", {15'd0, bus.frame_valid}, 16'd1);
    chk("f1_digits", bus.digits, 16'h0123);
    chk("f1_blank", {12'd0, bus.blank}, 16'h0000);
    chk("f1_err", {15'd0, bus.err}, 16'd0);
    @(negedge clk);
    chk("f1_fv_after", {15'd0, bus.frame_valid}, 16'd0);
    chk("f1_fv_count", 16'(fv_count), 16'd1);

    // Frame 2: blank digit 2, short glitch on digit 0 must not capture
    present(AN1, S9, 6);
    present(AN2, SB, 6);
    present(AN3, S6, 6);
    present(AN0, S8, 3);
    chk("glitch_no_fv", 16'(fv_count), 16'd1);
    chk("glitch_hold_digits", bus.digits, 16'h0123);
    present(AN0, S5, 6);
    chk("f2_fv_count", 16'(fv_count), 16'd2);
    chk("f2_digits", bus.digits, 16'h6F95);
    chk("f2_blank", {12'd0, bus.blank}, 16'h0004);
    chk("f2_err", {15'd0, bus.err}, 16'd0);

    // Frame 3: unrecognised pattern on digit 1
    present(AN0, S4, 6);
    bus.an  = AN1;
    bus.seg = SX;
    repeat (4) @(negedge clk);
    chk("f3_err_before", {15'd0, bus.err}, 16'd0);
    @(negedge clk);
    chk("f3_err_edge", {15'd0, bus.err}, 16'd1);
    chk("f3_digits_hold", bus.digits, 16'h6F95);
    @(negedge clk);
    present(AN2, S7, 6);
    present(AN3, S8, 6);
    chk("f3_fv_count", 16'(fv_count), 16'd3);
    chk("f3_digits", bus.digits, 16'h87E4);
    chk("f3_blank", {12'd0, bus.blank}, 16'h0000);
    chk("f3_err_sticky", {15'd0, bus.err}, 16'd1);

    // err_clr alone clears
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("errclr_clears", {15'd0, bus.err}, 16'd0);

    // err_clr coinciding with a bad capture: set wins
    bus.an  = AN1;
    bus.seg = SX;
    repeat (4) @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("set_wins", {15'd0, bus.err}, 16'd1);
    @(negedge clk);
    chk("set_wins_held", {15'd0, bus.err}, 16'd1);

    // Invalid enables never capture (mask holds digit 1 only)
    present(4'b1100, S2, 10);
    present(4'b1111, S2, 6);
    chk("bad_an_fv", 16'(fv_count), 16'd3);
    chk("bad_an_digits", bus.digits, 16'h87E4);
    present(AN0, SX, 6);
    present(AN2, S3, 6);
    chk("bad_an_no_frame", 16'(fv_count), 16'd3);

    // Reset mid-frame: immediate clear, partial mask discarded
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_digits", bus.digits, 16'hFFFF);
    chk("midrst_blank", {12'd0, bus.blank}, 16'h000F);
    chk("midrst_err", {15'd0, bus.err}, 16'd0);
    chk("midrst_fv", {15'd0, bus.frame_valid}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    present(AN3, S1, 6);
    present(AN1, S2, 6);
    chk("postrst_no_fv", 16'(fv_count), 16'd3);
    chk("postrst_digits", bus.digits, 16'hFFFF);
    present(AN0, S7, 6);
    present(AN2, S9, 6);
    chk("postrst_fv", 16'(fv_count), 16'd4);
    chk("postrst_frame", bus.digits, 16'h1927);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
